// File: rtl/rv32i_pkg.sv
// Shared rv32i integer-datapath widths and types.
package rv32i_pkg;

    localparam int unsigned XLEN           = 32;
    localparam int unsigned REG_ADDR_WIDTH = 5;
    localparam int unsigned NUM_REGS       = 2 ** REG_ADDR_WIDTH;

    typedef logic [REG_ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [XLEN-1:0]           xlen_t;

endpackage

// File: rtl/regfile_sb_if.sv
// Decode/writeback bus into the scoreboarded register file.
interface regfile_sb_if #(
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned MAX_PEND = 4
) ();
    import rv32i_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_PEND + 1);

    logic [NUM_RD*REG_ADDR_WIDTH-1:0] ra;
    logic [NUM_RD*XLEN-1:0]           rdata;
    logic [NUM_RD-1:0]                rbusy;
    logic                             wr_en;
    reg_addr_t                        wa;
    xlen_t                            wdata_in;
    logic                             iss_valid;
    reg_addr_t                        iss_rd;
    logic                             iss_ready;
    logic [CNT_W-1:0]                 pend_cnt;

    modport master (
        output ra, wr_en, wa, wdata_in, iss_valid, iss_rd,
        input  rdata, rbusy, iss_ready, pend_cnt
    );

    modport slave (
        input  ra, wr_en, wa, wdata_in, iss_valid, iss_rd,
        output rdata, rbusy, iss_ready, pend_cnt
    );

endinterface

// File: rtl/sb_tracker.sv
// Busy scoreboard for outstanding destination reservations plus pending-write counter.
module sb_tracker
    import rv32i_pkg::*;
#(
    parameter int unsigned MAX_PEND = 4,
    localparam int unsigned CNT_W   = $clog2(MAX_PEND + 1)
) (
    input  logic                clk,
    input  logic                areset,
    input  logic                wr_en_i,
    input  reg_addr_t           wa_i,
    input  logic                iss_valid_i,
    input  reg_addr_t           iss_rd_i,
    output logic [NUM_REGS-1:0] busy_o,
    output logic                iss_ready_o,
    output logic [CNT_W-1:0]    pend_cnt_o
);

    logic [NUM_REGS-1:0] busy_q, busy_d;
    logic [CNT_W-1:0]    pend_cnt_q, pend_cnt_d;
    logic                retire, accept, ready;

    // busy[iss_rd] is the pre-edge value, so a same-register retire never re-accepts
    always_comb begin
        retire = wr_en_i && (wa_i != '0) && busy_q[wa_i];
        ready  = (iss_rd_i == '0) ||
                 (!busy_q[iss_rd_i] && ((pend_cnt_q < CNT_W'(MAX_PEND)) || retire));
        accept = iss_valid_i && ready && (iss_rd_i != '0);

        busy_d = busy_q;
        if (retire) busy_d[wa_i]     = 1'b0;
        if (accept) busy_d[iss_rd_i] = 1'b1;

        pend_cnt_d = pend_cnt_q;
        case ({accept, retire})
            2'b10:   pend_cnt_d = pend_cnt_q + CNT_W'(1);
            2'b01:   pend_cnt_d = pend_cnt_q - CNT_W'(1);
            default: pend_cnt_d = pend_cnt_q;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            busy_q     <= '0;
            pend_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            pend_cnt_q <= pend_cnt_d;
        end
    end

    assign busy_o      = busy_q;
    assign iss_ready_o = ready;
    assign pend_cnt_o  = pend_cnt_q;

endmodule

// File: rtl/regfile_sb.sv
// Multi-port integer register file with long-latency writeback scoreboard.
// Define RF_BYPASS_EN to forward same-cycle writeback data onto matching read ports.
module regfile_sb
    import rv32i_pkg::*;
#(
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned MAX_PEND = 4
) (
    input  logic         clk,
    input  logic         areset,
    regfile_sb_if.slave  rf
);

    xlen_t                  regs_q [NUM_REGS];
    logic [NUM_REGS-1:0]    busy;
    logic [NUM_RD*XLEN-1:0] rdata_c;
    logic [NUM_RD-1:0]      rbusy_c;
    reg_addr_t              rd_addr;
    logic                   wr_fire;

    assign wr_fire = rf.wr_en && (rf.wa != '0);

    sb_tracker #(.MAX_PEND(MAX_PEND)) u_sb (
        .clk         (clk),
        .areset      (areset),
        .wr_en_i     (rf.wr_en),
        .wa_i        (rf.wa),
        .iss_valid_i (rf.iss_valid),
        .iss_rd_i    (rf.iss_rd),
        .busy_o      (busy),
        .iss_ready_o (rf.iss_ready),
        .pend_cnt_o  (rf.pend_cnt)
    );

    // x0 is never written, so it reads back as zero from reset onward
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            for (int unsigned r = 0; r < NUM_REGS; r++) regs_q[r] <= '0;
        end else if (wr_fire) begin
            regs_q[rf.wa] <= rf.wdata_in;
        end
    end

    always_comb begin
        rdata_c = '0;
        rbusy_c = '0;
        rd_addr = '0;
        for (int unsigned i = 0; i < NUM_RD; i++) begin
            rd_addr = rf.ra[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];
            rdata_c[i*XLEN +: XLEN] = regs_q[rd_addr];
            rbusy_c[i]              = busy[rd_addr];
`ifdef RF_BYPASS_EN
            if (wr_fire && (rd_addr == rf.wa)) begin
                rdata_c[i*XLEN +: XLEN] = rf.wdata_in;
                rbusy_c[i]              = 1'b0;
            end
`endif
        end
    end

    assign rf.rdata = rdata_c;
    assign rf.rbusy = rbusy_c;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (NUM_RD=2, MAX_PEND=4).
module tb_regfile_sb;
    import rv32i_pkg::*;

    logic clk = 1'b0;
    logic areset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    regfile_sb_if #(.NUM_RD(2), .MAX_PEND(4)) rf ();

    regfile_sb #(.NUM_RD(2), .MAX_PEND(4)) dut (
        .clk    (clk),
        .areset (areset),
        .rf     (rf)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf.wr_en     = 1'b0;
        rf.wa        = '0;
        rf.wdata_in  = '0;
        rf.iss_valid = 1'b0;
        rf.iss_rd    = '0;
    endtask

    task automatic set_ra(input int p1, input int p0);
        rf.ra = {5'(p1), 5'(p0)};
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        rf.wr_en    = 1'b1;
        rf.wa       = 5'(a);
        rf.wdata_in = d;
    endtask

    task automatic iss(input int a);
        rf.iss_valid = 1'b1;
        rf.iss_rd    = 5'(a);
    endtask

    initial begin
        idle();
        set_ra(5, 0);
        // reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_rdata", 64'(rf.rdata), 64'h0);
        check("rst_rbusy", 64'(rf.rbusy), 64'h0);
        check("rst_ready", 64'(rf.iss_ready), 64'h1);
        check("rst_pend", 64'(rf.pend_cnt), 64'h0);
        @(negedge clk);
        areset = 1'b0;
        tick();

        // write and read back; x0 drops writes
        wr(3, 32'hDEADBEEF);
        tick();
        idle();
        set_ra(0, 3);
        #1;
        check("wr_x3", 64'(rf.rdata[31:0]), 64'hDEADBEEF);
        wr(0, 32'h1);
        tick();
        idle();
        set_ra(3, 0);
        #1;
        check("wr_x0", 64'(rf.rdata[31:0]), 64'h0);
        check("rd_p1_x3", 64'(rf.rdata[63:32]), 64'hDEADBEEF);

        // issue to x0 accepted, no count
        iss(0);
        #1;
        check("iss_x0_ready", 64'(rf.iss_ready), 64'h1);
        tick();
        idle();
        #1;
        check("iss_x0_pend", 64'(rf.pend_cnt), 64'h0);
        set_ra(0, 0);
        #1;
        check("iss_x0_rbusy", 64'(rf.rbusy), 64'h0);

        // fill scoreboard x1..x4
        for (int k = 1; k <= 4; k++) begin
            iss(k);
            #1;
            check("fill_ready", 64'(rf.iss_ready), 64'h1);
            tick();
            idle();
            #1;
            check("fill_pend", 64'(rf.pend_cnt), 64'(k));
        end
        set_ra(1, 2);
        #1;
        check("fill_rbusy12", 64'(rf.rbusy), 64'h3);
        set_ra(3, 4);
        #1;
        check("fill_rbusy34", 64'(rf.rbusy), 64'h3);

        // full: x5 rejected, then accepted alongside retire of x2
        iss(5);
        #1;
        check("full_reject", 64'(rf.iss_ready), 64'h0);
        tick();
        #1;
        check("full_no_side", 64'(rf.pend_cnt), 64'h4);
        wr(2, 32'h22);
        #1;
        check("full_retire_ready", 64'(rf.iss_ready), 64'h1);
        tick();
        idle();
        set_ra(5, 2);
        #1;
        check("swap_pend", 64'(rf.pend_cnt), 64'h4);
        check("swap_rbusy52", 64'(rf.rbusy), 64'h2);
        check("swap_x2", 64'(rf.rdata[31:0]), 64'h22);
        set_ra(1, 3);
        #1;
        check("swap_rbusy13", 64'(rf.rbusy), 64'h3);
        set_ra(4, 0);
        #1;
        check("swap_rbusy40", 64'(rf.rbusy), 64'h2);

        // drain
        wr(1, 32'h11); tick();
        wr(3, 32'h33); tick();
        wr(4, 32'h44); tick();
        check("drain_pend1", 64'(rf.pend_cnt), 64'h1);
        wr(5, 32'h55); tick();
        idle();
        #1;
        check("drain_pend0", 64'(rf.pend_cnt), 64'h0);

        // same-register collision on x7
        iss(7); tick();
        idle();
        #1;
        check("x7_pend", 64'(rf.pend_cnt), 64'h1);
        wr(7, 32'h77);
        iss(7);
        set_ra(7, 0);
        #1;
        check("coll_ready", 64'(rf.iss_ready), 64'h0);
        tick();
        idle();
        #1;
        check("coll_pend", 64'(rf.pend_cnt), 64'h0);
        check("coll_rbusy", 64'(rf.rbusy), 64'h0);
        check("coll_data", 64'(rf.rdata[63:32]), 64'h77);
        iss(7);
        #1;
        check("retry_ready", 64'(rf.iss_ready), 64'h1);
        tick();
        idle();
        #1;
        check("retry_pend", 64'(rf.pend_cnt), 64'h1);
        check("retry_rbusy", 64'(rf.rbusy), 64'h2);

        // forwarding / write visibility on port 1, x9 busy
        iss(9); tick();
        idle();
        set_ra(9, 0);
        wr(9, 32'h55);
        #1;
`ifdef RF_BYPASS_EN
        check("byp_data", 64'(rf.rdata[63:32]), 64'h55);
        check("byp_rbusy", 64'(rf.rbusy), 64'h0);
`else
        check("nobyp_data", 64'(rf.rdata[63:32]), 64'h0);
        check("nobyp_rbusy", 64'(rf.rbusy), 64'h2);
`endif
        tick();
        idle();
        #1;
        check("byp_after", 64'(rf.rdata[63:32]), 64'h55);
        check("byp_pend", 64'(rf.pend_cnt), 64'h1);

        // plain write to non-busy register keeps count
        wr(3, 32'h3333); tick();
        idle();
        set_ra(3, 7);
        #1;
        check("plain_pend", 64'(rf.pend_cnt), 64'h1);
        check("plain_data", 64'(rf.rdata[63:32]), 64'h3333);

        // reset mid-operation with 3 pending and a write in flight
        iss(10); tick();
        iss(11); tick();
        idle();
        #1;
        check("pre_rst_pend", 64'(rf.pend_cnt), 64'h3);
        wr(12, 32'hAB);
        set_ra(7, 3);
        #2;
        areset = 1'b1;
        #1;
        check("mid_rst_pend", 64'(rf.pend_cnt), 64'h0);
        check("mid_rst_rbusy", 64'(rf.rbusy), 64'h0);
        check("mid_rst_rdata", 64'(rf.rdata), 64'h0);
        check("mid_rst_ready", 64'(rf.iss_ready), 64'h1);
        tick();
        idle();
        areset = 1'b0;
        set_ra(12, 10);
        tick();
        check("post_rst_x12", 64'(rf.rdata), 64'h0);
        check("post_rst_rbusy", 64'(rf.rbusy), 64'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
